// File: rtl/valu_wb_collector_pkg.sv
// Shared definitions for the VALU writeback collector: FSM encodings, metadata
// widths and the captured-instruction record.
package valu_wb_collector_pkg;

  localparam int WFID_W      = 6;
  localparam int PC_W        = 32;
  localparam int VGPR_ADDR_W = 10;
  localparam int WAVE_W      = 64;

  typedef enum logic [1:0] {
    WBC_IDLE    = 2'b00,
    WBC_COLLECT = 2'b01,
    WBC_WRITE   = 2'b10
  } wbc_state_t;

  typedef struct packed {
    logic [WFID_W-1:0]      wfid;
    logic [PC_W-1:0]        pc;
    logic [VGPR_ADDR_W-1:0] addr;
  } wbc_meta_t;

  // Pass index width; a single-pass build still gets a 1-bit counter.
  function automatic int pcnt_w(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic state cell: synchronous active-high reset with load enable.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/valu_wb_collector_slice_buf.sv
// wbc_slice_buf: PASSES rows of LANES*DATA_W, row selected by pass index on
// write, all rows presented together as one flat wavefront vector.
module wbc_slice_buf
  import valu_wb_collector_pkg::*;
#(
  parameter  int PASSES = 4,
  parameter  int LANES  = 16,
  parameter  int DATA_W = 32,
  localparam int SW     = LANES * DATA_W,
  localparam int IDX_W  = pcnt_w(PASSES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [SW-1:0]        din,
  output logic [PASSES*SW-1:0] dout
);

  for (genvar p = 0; p < PASSES; p++) begin : g_pass
    dff #(.W(SW)) u_row (
      .clk (clk),
      .rst (rst),
      .en  (we && (idx == IDX_W'(p))),
      .d   (din),
      .q   (dout[p*SW +: SW])
    );
  end

endmodule

// File: rtl/valu_wb_collector.sv
// Collects PASSES narrow VALU results into one wavefront VGPR write and
// cross-checks the ALU FSM's WB strobe. Optional VCC assembly: WB_COLLECTOR_VCC_EN.
module valu_wb_collector
  import valu_wb_collector_pkg::*;
#(
  parameter  int LANES  = 16,
  parameter  int DATA_W = 32,
  parameter  int PASSES = 4,
  localparam int WAVE   = LANES * PASSES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_rd,
  input  logic [WFID_W-1:0]         in_wfid,
  input  logic [PC_W-1:0]           in_instr_pc,
  input  logic [VGPR_ADDR_W-1:0]    in_vgpr_dest_addr,
  input  logic [WAVE-1:0]           in_exec_mask,
  input  logic                      in_valu_done,
  input  logic [LANES*DATA_W-1:0]   in_valu_result,
`ifdef WB_COLLECTOR_VCC_EN
  input  logic [LANES-1:0]          in_valu_vcc,
`endif
  input  logic                      in_wb,
  input  logic                      in_wb_ready,
  output logic                      out_wb_valid,
  output logic [WFID_W-1:0]         out_wb_wfid,
  output logic [PC_W-1:0]           out_wb_pc,
  output logic [VGPR_ADDR_W-1:0]    out_vgpr_addr,
  output logic [WAVE*DATA_W-1:0]    out_vgpr_data,
  output logic [WAVE-1:0]           out_vgpr_wr_mask,
`ifdef WB_COLLECTOR_VCC_EN
  output logic [WAVE-1:0]           out_vcc_value,
`endif
  output logic                      out_collector_ready,
  output logic                      out_seq_err
);

  localparam int PCNT_W = pcnt_w(PASSES);

  logic [1:0]        state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              err_q, err_d;
  logic              idle, collect, write;
  logic              capture, beat, last_beat;
  wbc_meta_t         meta_in, meta_q;

  assign idle      = (state_q == WBC_IDLE);
  assign collect   = (state_q == WBC_COLLECT);
  assign write     = (state_q == WBC_WRITE);
  assign capture   = idle && in_rd;
  assign beat      = collect && in_valu_done;
  assign last_beat = beat && (pcnt_q == PCNT_W'(PASSES - 1));

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    case (state_q)
      WBC_IDLE: begin
        if (in_rd) begin
          state_d = WBC_COLLECT;
          pcnt_d  = '0;
        end
        if (in_valu_done || in_wb) err_d = 1'b1;
      end
      WBC_COLLECT: begin
        if (beat) pcnt_d = last_beat ? '0 : pcnt_q + 1'b1;
        if (last_beat) state_d = WBC_WRITE;
        // WB must coincide with the final beat and nothing else; the beat
        // count alone decides the transition.
        if (in_rd || (in_wb != last_beat)) err_d = 1'b1;
      end
      WBC_WRITE: begin
        if (in_wb_ready) state_d = WBC_IDLE;
        if (in_rd || in_valu_done || in_wb) err_d = 1'b1;
      end
      default: state_d = WBC_IDLE;
    endcase
  end

  dff #(.W(2)) u_state (
    .clk (clk), .rst (rst), .en (1'b1), .d (state_d), .q (state_q)
  );

  dff #(.W(PCNT_W)) u_pcnt (
    .clk (clk), .rst (rst), .en (1'b1), .d (pcnt_d), .q (pcnt_q)
  );

  dff #(.W(1)) u_err (
    .clk (clk), .rst (rst), .en (1'b1), .d (err_d), .q (err_q)
  );

  always_comb begin
    meta_in      = '0;
    meta_in.wfid = in_wfid;
    meta_in.pc   = in_instr_pc;
    meta_in.addr = in_vgpr_dest_addr;
  end

  dff #(.W($bits(wbc_meta_t))) u_meta (
    .clk (clk), .rst (rst), .en (capture), .d (meta_in), .q (meta_q)
  );

  dff #(.W(WAVE)) u_exec (
    .clk (clk), .rst (rst), .en (capture), .d (in_exec_mask), .q (out_vgpr_wr_mask)
  );

  // Payload only moves on COLLECT beats, so it is frozen throughout WRITE.
  wbc_slice_buf #(.PASSES(PASSES), .LANES(LANES), .DATA_W(DATA_W)) u_data (
    .clk  (clk),
    .rst  (rst),
    .we   (beat),
    .idx  (pcnt_q),
    .din  (in_valu_result),
    .dout (out_vgpr_data)
  );

`ifdef WB_COLLECTOR_VCC_EN
  wbc_slice_buf #(.PASSES(PASSES), .LANES(LANES), .DATA_W(1)) u_vcc (
    .clk  (clk),
    .rst  (rst),
    .we   (beat),
    .idx  (pcnt_q),
    .din  (in_valu_vcc),
    .dout (out_vcc_value)
  );
`endif

  assign out_wb_valid        = write;
  assign out_collector_ready = idle;
  assign out_seq_err         = err_q;
  assign out_wb_wfid         = meta_q.wfid;
  assign out_wb_pc           = meta_q.pc;
  assign out_vgpr_addr       = meta_q.addr;

endmodule

// File: tb/tb_valu_wb_collector.sv
// Directed bench for valu_wb_collector: transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_valu_wb_collector;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int PASSES = 4;
  localparam int WAVE   = LANES * PASSES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_rd, in_valu_done, in_wb, in_wb_ready;
  logic [5:0]              in_wfid;
  logic [31:0]             in_instr_pc;
  logic [9:0]              in_vgpr_dest_addr;
  logic [WAVE-1:0]         in_exec_mask;
  logic [LANES*DATA_W-1:0] in_valu_result;
  logic                    out_wb_valid, out_collector_ready, out_seq_err;
  logic [5:0]              out_wb_wfid;
  logic [31:0]             out_wb_pc;
  logic [9:0]              out_vgpr_addr;
  logic [WAVE*DATA_W-1:0]  out_vgpr_data;
  logic [WAVE-1:0]         out_vgpr_wr_mask;
`ifdef WB_COLLECTOR_VCC_EN
  logic [LANES-1:0]        in_valu_vcc;
  logic [WAVE-1:0]         out_vcc_value;
  logic [LANES-1:0]        vcc_tab [PASSES] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555};
`endif

  always #5 clk = ~clk;

  valu_wb_collector #(.LANES(LANES), .DATA_W(DATA_W), .PASSES(PASSES)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_rd               (in_rd),
    .in_wfid             (in_wfid),
    .in_instr_pc         (in_instr_pc),
    .in_vgpr_dest_addr   (in_vgpr_dest_addr),
    .in_exec_mask        (in_exec_mask),
    .in_valu_done        (in_valu_done),
    .in_valu_result      (in_valu_result),
`ifdef WB_COLLECTOR_VCC_EN
    .in_valu_vcc         (in_valu_vcc),
`endif
    .in_wb               (in_wb),
    .in_wb_ready         (in_wb_ready),
    .out_wb_valid        (out_wb_valid),
    .out_wb_wfid         (out_wb_wfid),
    .out_wb_pc           (out_wb_pc),
    .out_vgpr_addr       (out_vgpr_addr),
    .out_vgpr_data       (out_vgpr_data),
    .out_vgpr_wr_mask    (out_vgpr_wr_mask),
`ifdef WB_COLLECTOR_VCC_EN
    .out_vcc_value       (out_vcc_value),
`endif
    .out_collector_ready (out_collector_ready),
    .out_seq_err         (out_seq_err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: busy = gathering beats, pend = write offered.
  bit          m_busy, m_pend, m_err;
  int          m_beats;
  logic [5:0]  m_wfid;
  logic [31:0] m_pc;
  logic [9:0]  m_addr;
  logic [63:0] m_exec;
  logic [31:0] m_lane [WAVE];
`ifdef WB_COLLECTOR_VCC_EN
  logic [63:0] m_vcc;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_pend = 0; m_err = 0; m_beats = 0;
      m_wfid = '0; m_pc = '0; m_addr = '0; m_exec = '0;
      for (int l = 0; l < WAVE; l++) m_lane[l] = '0;
`ifdef WB_COLLECTOR_VCC_EN
      m_vcc = '0;
`endif
    end else if (m_pend) begin
      if (in_rd || in_valu_done || in_wb) m_err = 1;
      if (in_wb_ready) m_pend = 0;
    end else if (m_busy) begin
      if (in_rd) m_err = 1;
      if (in_valu_done) begin
        for (int k = 0; k < LANES; k++) begin
          m_lane[m_beats*LANES + k] = in_valu_result[k*DATA_W +: DATA_W];
`ifdef WB_COLLECTOR_VCC_EN
          m_vcc[m_beats*LANES + k] = in_valu_vcc[k];
`endif
        end
        m_beats++;
      end
      if (in_wb != (in_valu_done && m_beats == PASSES)) m_err = 1;
      if (m_beats == PASSES) begin
        m_busy = 0; m_pend = 1; m_beats = 0;
      end
    end else begin
      if (in_valu_done || in_wb) m_err = 1;
      if (in_rd) begin
        m_wfid = in_wfid; m_pc = in_instr_pc; m_addr = in_vgpr_dest_addr;
        m_exec = in_exec_mask; m_busy = 1; m_beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      bad = 0;
      chk("wb_valid", 64'(out_wb_valid), 64'(m_pend));
      chk("collector_ready", 64'(out_collector_ready), 64'(!(m_busy || m_pend)));
      chk("seq_err", 64'(out_seq_err), 64'(m_err));
      chk("wfid", 64'(out_wb_wfid), 64'(m_wfid));
      chk("pc", 64'(out_wb_pc), 64'(m_pc));
      chk("vgpr_addr", 64'(out_vgpr_addr), 64'(m_addr));
      chk("wr_mask", out_vgpr_wr_mask, m_exec);
      for (int l = WAVE - 1; l >= 0; l--)
        if (out_vgpr_data[l*DATA_W +: DATA_W] !== m_lane[l]) bad = l;
      chk($sformatf("data_lane%0d", bad), 64'(out_vgpr_data[bad*DATA_W +: DATA_W]), 64'(m_lane[bad]));
`ifdef WB_COLLECTOR_VCC_EN
      chk("vcc", out_vcc_value, m_vcc);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DATA_W-1:0] pass_data(input int base, input int p);
    logic [LANES*DATA_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = DATA_W'(base + 'h100*p + k);
    return r;
  endfunction

  task automatic issue(input logic [5:0] w, input logic [31:0] pc, input logic [9:0] a,
                       input logic [63:0] e);
    in_rd = 1; in_wfid = w; in_instr_pc = pc; in_vgpr_dest_addr = a; in_exec_mask = e;
    step();
    in_rd = 0;
  endtask

  task automatic beats(input int base, input logic [3:0] wbm, input int p0, input int p1);
    for (int p = p0; p < p1; p++) begin
      in_valu_done = 1; in_wb = wbm[p]; in_valu_result = pass_data(base, p);
`ifdef WB_COLLECTOR_VCC_EN
      in_valu_vcc = vcc_tab[p];
`endif
      step();
    end
    in_valu_done = 0; in_wb = 0;
  endtask

  // Hold ready low for 'stall' cycles, then accept; count cycles with valid.
  task automatic drain(input int stall, output int vcnt);
    vcnt = 0;
    for (int i = 0; i <= stall; i++) begin
      in_wb_ready = (i == stall);
      if (out_wb_valid) vcnt++;
      step();
    end
    in_wb_ready = 0;
    if (out_wb_valid) vcnt++;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    int vc;
    rst = 1; in_rd = 0; in_valu_done = 0; in_wb = 0; in_wb_ready = 0;
    in_wfid = '0; in_instr_pc = '0; in_vgpr_dest_addr = '0; in_exec_mask = '0;
    in_valu_result = '0;
`ifdef WB_COLLECTOR_VCC_EN
    in_valu_vcc = '0;
`endif
    step();
    chk_en = 1;
    step(); rst = 0;
    chk("rst_valid", 64'(out_wb_valid), 64'd0);
    chk("rst_ready", 64'(out_collector_ready), 64'd1);
    chk("rst_err", 64'(out_seq_err), 64'd0);
    chk("rst_data_zero", 64'(|out_vgpr_data), 64'd0);

    // Nominal
    issue(6'd5, 32'h0000_0100, 10'h012, '1);
    chk("nom_ready_low", 64'(out_collector_ready), 64'd0);
    beats(0, 4'b1000, 0, 4);
    drain(0, vc);
    chk("nom_valid_cycles", 64'(vc), 64'd1);
    chk("nom_lane17", 64'(out_vgpr_data[17*DATA_W +: DATA_W]), 64'h101);
    chk("nom_lane63", 64'(out_vgpr_data[63*DATA_W +: DATA_W]), 64'h30F);
    chk("nom_wfid", 64'(out_wb_wfid), 64'd5);
    chk("nom_addr", 64'(out_vgpr_addr), 64'h012);
    chk("nom_err", 64'(out_seq_err), 64'd0);

    // Backpressure
    issue(6'd9, 32'h0000_0200, 10'h3A1, 64'hF0F0_1234_0000_FFFF);
    beats('h7000, 4'b1000, 0, 4);
    drain(5, vc);
    chk("bp_valid_cycles", 64'(vc), 64'd6);
    chk("bp_lane33", 64'(out_vgpr_data[33*DATA_W +: DATA_W]), 64'h7201);

    // Done while idle
    in_valu_done = 1; step(); in_valu_done = 0;
    chk("idle_done_err", 64'(out_seq_err), 64'd1);
    chk("idle_done_ready", 64'(out_collector_ready), 64'd1);

    // WB on the second beat
    do_reset();
    issue(6'd1, 32'h0000_0300, 10'h044, '1);
    beats('h50, 4'b0010, 0, 2);
    chk("wb_early_err", 64'(out_seq_err), 64'd1);
    beats('h50, 4'b0010, 2, 4);
    drain(0, vc);
    chk("wb_early_valid_cycles", 64'(vc), 64'd1);

    // Reset mid-collect
    issue(6'd2, 32'h0000_0400, 10'h155, '1);
    beats('h900, 4'b1000, 0, 2);
    rst = 1; step(); rst = 0;
    chk("midrst_ready", 64'(out_collector_ready), 64'd1);
    chk("midrst_valid", 64'(out_wb_valid), 64'd0);
    chk("midrst_data_zero", 64'(|out_vgpr_data), 64'd0);
    chk("midrst_mask_zero", out_vgpr_wr_mask, 64'd0);
    issue(6'd3, 32'h0000_0500, 10'h200, 64'h0000_FFFF_0000_FFFF);
    beats('h20, 4'b1000, 0, 4);
    drain(0, vc);
    chk("after_rst_valid_cycles", 64'(vc), 64'd1);
    chk("after_rst_err", 64'(out_seq_err), 64'd0);

    // Back-to-back
    issue(6'd10, 32'h0000_0600, 10'h010, '1);
    beats('h40, 4'b1000, 0, 4);
    drain(0, vc);
    chk("b2b_a_valid_cycles", 64'(vc), 64'd1);
`ifdef WB_COLLECTOR_VCC_EN
    chk("b2b_a_vcc", out_vcc_value, 64'h5555_AAAA_0000_FFFF);
`endif
    issue(6'd11, 32'h0000_0700, 10'h011, '1);
    chk("b2b_b_accepted", 64'(out_collector_ready), 64'd0);
    chk("b2b_b_wfid", 64'(out_wb_wfid), 64'd11);
    beats('h80, 4'b1000, 0, 4);
    drain(0, vc);
    chk("b2b_b_valid_cycles", 64'(vc), 64'd1);
    chk("b2b_err", 64'(out_seq_err), 64'd0);
`ifdef WB_COLLECTOR_VCC_EN
    chk("b2b_b_vcc", out_vcc_value, 64'h5555_AAAA_0000_FFFF);
`endif
    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
